// File: rtl/cordic_fx_engine_if.sv
// TinyQV peripheral bus bundle: byte-addressed sized writes, single-cycle side-effect-free reads.
interface cordic_fx_engine_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (output address, data_in, data_write_n, data_read_n,
                  input  data_out, data_ready);
  modport slave  (input  address, data_in, data_write_n, data_read_n,
                  output data_out, data_ready);
endinterface

// File: rtl/cordic_fx_engine.sv
// Iterative CORDIC (rotate: sin/cos, vector: magnitude/atan2), one micro-rotation per clock.
// START to results is ITERATIONS+2 cycles; bus never stalls, START while busy only flags OVERRUN.
module cordic_fx_engine #(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ui_in,
  output logic [7:0]        uo_out,
  output logic              user_interrupt,
  cordic_fx_engine_if.slave bus
);
  localparam int WW = WIDTH + 2;
  localparam logic [WIDTH-1:0] QTR  = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  // atan(2^-i) as a fraction of the full circle scaled to 2^32
  localparam logic [31:0] ATAN32 [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER} state_t;
  state_t state_q, state_d;

  logic signed [WIDTH-1:0] x_in_q, y_in_q, z_in_q, z_out_q;
  logic signed [WW-1:0]    x_out_q, y_out_q;
  logic                    mode_ctl_q, irq_en_q, done_q, overrun_q, mode_q;
  logic signed [WW-1:0]    x_q, y_q, x_pre, y_pre, x_it, y_it;
  logic [WIDTH-1:0]        z_q, z_pre, z_it, atan_i;
  logic [32:0]             atan_rnd;
  logic [4:0]              i_q;
  logic                    d_pos, last_it, busy, accept, finish;

  logic [31:0] wmask, wdat, rd, x_in_nxt, y_in_nxt, z_in_nxt;
  logic [7:0]  wr_hit;
  logic        start_req, abort_req, ovr_set, done_clr, ovr_clr, mode_sel;
  logic        unused_inputs;

  assign unused_inputs = ^{ui_in, bus.data_read_n};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] m,
                                        input logic [31:0] d);
    return (old & ~m) | (d & m);
  endfunction

  // Sized writes: lane data is replicated, the mask picks the lane(s) at address[1:0]
  always_comb begin
    wmask = '0;
    wdat  = bus.data_in;
    case (bus.data_write_n)
      2'b00: begin
        wmask = 32'h0000_00FF << {bus.address[1:0], 3'b000};
        wdat  = {4{bus.data_in[7:0]}};
      end
      2'b01: begin
        wmask = 32'h0000_FFFF << {bus.address[1], 4'b0000};
        wdat  = {2{bus.data_in[15:0]}};
      end
      2'b10:   wmask = '1;
      default: wmask = '0;
    endcase
    wr_hit = '0;
    if (wmask != '0 && !bus.address[5]) wr_hit[bus.address[4:2]] = 1'b1;
    x_in_nxt  = merge(32'(x_in_q), wmask, wdat);
    y_in_nxt  = merge(32'(y_in_q), wmask, wdat);
    z_in_nxt  = merge(32'(z_in_q), wmask, wdat);
    abort_req = wr_hit[3] & wmask[3] & wdat[3];
    start_req = wr_hit[3] & wmask[0] & wdat[0] & ~abort_req;
    mode_sel  = (wr_hit[3] & wmask[1]) ? wdat[1] : mode_ctl_q;
    done_clr  = wr_hit[7] & wmask[1] & wdat[1];
    ovr_clr   = wr_hit[7] & wmask[2] & wdat[2];
  end

  always_comb begin
    x_pre = x_q;
    y_pre = y_q;
    z_pre = z_q;
    if (mode_q) begin
      if (x_q[WW-1]) begin
        x_pre = -x_q;
        y_pre = -y_q;
        z_pre = z_q + HALF;
      end
    end else if (z_q[WIDTH-1:WIDTH-2] == 2'b01) begin
      x_pre = -y_q;
      y_pre = x_q;
      z_pre = z_q - QTR;
    end else if (z_q[WIDTH-1:WIDTH-2] == 2'b10) begin
      x_pre = y_q;
      y_pre = -x_q;
      z_pre = z_q + QTR;
    end
    atan_rnd = {1'b0, ATAN32[i_q]} + (33'd1 << (31 - WIDTH));
    atan_i   = atan_rnd[32-WIDTH +: WIDTH];
    // d=+1: rotate when z>=0, vector when y<0
    d_pos = mode_q ? y_q[WW-1] : ~z_q[WIDTH-1];
    if (d_pos) begin
      x_it = x_q - (y_q >>> i_q);
      y_it = y_q + (x_q >>> i_q);
      z_it = z_q - atan_i;
    end else begin
      x_it = x_q + (y_q >>> i_q);
      y_it = y_q - (x_q >>> i_q);
      z_it = z_q + atan_i;
    end
  end

  assign last_it = (i_q == 5'(ITERATIONS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_req) state_d = S_LOAD;
      S_LOAD:  state_d = S_ITER;
      S_ITER:  if (last_it) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_IDLE;
    busy    = (state_q != S_IDLE);
    accept  = (state_q == S_IDLE) && start_req;
    ovr_set = busy && start_req;
    finish  = (state_q == S_ITER) && last_it && !abort_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_in_q     <= '0;
      y_in_q     <= '0;
      z_in_q     <= '0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      z_out_q    <= '0;
      mode_ctl_q <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      mode_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      i_q        <= '0;
    end else begin
      state_q <= state_d;
      if (wr_hit[0]) x_in_q <= x_in_nxt[WIDTH-1:0];
      if (wr_hit[1]) y_in_q <= y_in_nxt[WIDTH-1:0];
      if (wr_hit[2]) z_in_q <= z_in_nxt[WIDTH-1:0];
      if (wr_hit[3] && wmask[1]) mode_ctl_q <= wdat[1];
      if (wr_hit[3] && wmask[2]) irq_en_q   <= wdat[2];
      if (accept) begin
        mode_q <= mode_sel;
        x_q    <= WW'(x_in_q);
        y_q    <= WW'(y_in_q);
        z_q    <= z_in_q;
      end
      if (state_q == S_LOAD) begin
        x_q <= x_pre;
        y_q <= y_pre;
        z_q <= z_pre;
        i_q <= '0;
      end
      if (state_q == S_ITER) begin
        x_q <= x_it;
        y_q <= y_it;
        z_q <= z_it;
        i_q <= i_q + 5'd1;
      end
      if (finish) begin
        x_out_q <= x_it;
        y_out_q <= y_it;
        z_out_q <= z_it;
      end
      // a set in the same cycle as a W1C takes priority
      done_q    <= finish  | (done_q & ~accept & ~done_clr);
      overrun_q <= ovr_set | (overrun_q & ~ovr_clr);
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address[5:2])
      4'h0:    rd = 32'(x_in_q);
      4'h1:    rd = 32'(y_in_q);
      4'h2:    rd = 32'(z_in_q);
      4'h3:    rd = {29'd0, irq_en_q, mode_ctl_q, 1'b0};
      4'h4:    rd = 32'(x_out_q);
      4'h5:    rd = 32'(y_out_q);
      4'h6:    rd = 32'(z_out_q);
      4'h7:    rd = {29'd0, overrun_q, done_q, busy};
      default: rd = '0;
    endcase
  end

  assign bus.data_out    = rd;
  assign bus.data_ready  = 1'b1;
  assign uo_out          = {5'b0, done_q, busy, 1'b0};
  assign user_interrupt  = done_q & irq_en_q;
endmodule

// File: tb/tb_cordic_fx_engine.sv
// Bench for cordic_fx_engine: directed and random operations against a real-valued trig model.
module tb_cordic_fx_engine;
  localparam real A  = 1.6467602581;
  localparam real PI = 3.14159265358979;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic       user_interrupt;
  int         checks = 0;
  int         errors = 0;

  cordic_fx_engine_if bus();

  cordic_fx_engine #(.WIDTH(16), .ITERATIONS(16)) dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .user_interrupt(user_interrupt), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic int ang_err(input int act, input int exp_v);
    logic signed [15:0] d;
    d = 16'(act - exp_v);
    return (d < 0) ? -int'(d) : int'(d);
  endfunction

  function automatic real bam2rad(input int z);
    return real'(z) * 2.0 * PI / 65536.0;
  endfunction

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz = 2'b10);
    @(negedge clk);
    bus.address = a;
    bus.data_in = d;
    bus.data_write_n = sz;
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.data_read_n = 2'b10;
    #1;
    d = bus.data_out;
    bus.data_read_n = 2'b11;
  endtask

  task automatic start_op(input bit mode, input int x, input int y, input int z, input bit irq);
    bus_write(6'h00, 32'(x));
    bus_write(6'h04, 32'(y));
    bus_write(6'h08, 32'(z));
    bus_write(6'h0C, {29'd0, irq, mode, 1'b1});
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (uo_out[2] !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (uo_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: DONE=%b after %0d cycles, required 1", tag, uo_out[2], n);
    end
  endtask

  task automatic read_results(output int xo, output int yo, output int zo);
    logic [31:0] r;
    bus_read(6'h10, r); xo = int'(r);
    bus_read(6'h14, r); yo = int'(r);
    bus_read(6'h18, r); zo = int'(r);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    checks++;
    if (uo_out !== 8'h00 || user_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: uo_out=%h irq=%b, required 00/0", uo_out, user_interrupt);
    end
    checks++;
    if (bus.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_data_ready: got %b, required 1", bus.data_ready);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(6'(a * 4), r);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg_%0h: got %h, required 00000000", a * 4, r);
      end
    end
  endtask

  task automatic test_rotate_directed();
    int xin [3] = '{9949, 9949, 9949};
    int zin [3] = '{32'h2000, 32'h8000, 32'h6000};
    int ex  [3] = '{11585, -16384, -11585};
    int ey  [3] = '{11585, 0, 11585};
    int xo, yo, zo, bad;
    for (int k = 0; k < 3; k++) begin
      start_op(1'b0, xin[k], 0, zin[k], 1'b0);
      if (k == 0) begin
        bad = 0;
        for (int c = 0; c < 17; c++) begin
          if (!(uo_out[1] === 1'b1 && uo_out[2] === 1'b0)) bad++;
          @(posedge clk);
          #1;
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL latency_busy_window: %0d of 17 cycles wrong, required 0", bad);
        end
        checks++;
        if (uo_out[2:1] !== 2'b10) begin
          errors++;
          $display("FAIL latency_done_edge: DONE,BUSY=%b, required 10", uo_out[2:1]);
        end
      end else begin
        wait_done("rot_dir");
      end
      read_results(xo, yo, zo);
      checks++;
      if (rabs(real'(xo - ex[k])) > 4.0 || rabs(real'(yo - ey[k])) > 4.0) begin
        errors++;
        $display("FAIL rot_dir_%0d: X=%0d Y=%0d, required %0d %0d +/-4", k, xo, yo, ex[k], ey[k]);
      end
      checks++;
      if (zo > 2 || zo < -2) begin
        errors++;
        $display("FAIL rot_dir_z_%0d: Z=%0d, required |Z|<=2", k, zo);
      end
    end
  endtask

  task automatic test_vector_directed();
    int xin [3] = '{10000, -10000, 10000};
    int yin [3] = '{10000, 0, 10000};
    int zin [3] = '{0, 0, 32'h7000};
    int ex  [3] = '{23289, 16468, 23289};
    int ez  [3] = '{32'h2000, 32'h8000, -28672};
    int xo, yo, zo;
    for (int k = 0; k < 3; k++) begin
      start_op(1'b1, xin[k], yin[k], zin[k], 1'b0);
      wait_done("vec_dir");
      read_results(xo, yo, zo);
      checks++;
      if (rabs(real'(xo - ex[k])) > 4.0) begin
        errors++;
        $display("FAIL vec_dir_x_%0d: X=%0d, required %0d +/-4", k, xo, ex[k]);
      end
      checks++;
      if ((k == 2) ? (rabs(real'(zo - ez[k])) > 2.0) : (ang_err(zo, ez[k]) > 2)) begin
        errors++;
        $display("FAIL vec_dir_z_%0d: Z=%0d, required %0d +/-2", k, zo, ez[k]);
      end
    end
  endtask

  task automatic test_random();
    int x, y, z, xo, yo, zo, ea;
    real ex, ey, ang;
    bit mode;
    for (int k = 0; k < 24; k++) begin
      mode = (k % 2) == 1;
      for (int t = 0; t < 100; t++) begin
        x = int'($urandom_range(16000)) - 8000;
        y = int'($urandom_range(16000)) - 8000;
        if (!mode || (x * x + y * y >= 16000000)) break;
      end
      z = int'($urandom_range(65535));
      start_op(mode, x, y, z, 1'b0);
      wait_done("rand");
      read_results(xo, yo, zo);
      if (!mode) begin
        ang = bam2rad(z);
        ex = A * (real'(x) * $cos(ang) - real'(y) * $sin(ang));
        ey = A * (real'(y) * $cos(ang) + real'(x) * $sin(ang));
        checks++;
        if (rabs(real'(xo) - ex) > 12.0 || rabs(real'(yo) - ey) > 12.0) begin
          errors++;
          $display("FAIL rand_rot x=%0d y=%0d z=%0d: X=%0d Y=%0d, required %0.1f %0.1f +/-12",
                   x, y, z, xo, yo, ex, ey);
        end
        checks++;
        if (zo > 3 || zo < -3) begin
          errors++;
          $display("FAIL rand_rot_z z=%0d: Z=%0d, required |Z|<=3", z, zo);
        end
      end else begin
        ex = A * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        ea = z + $rtoi($floor($atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI) + 0.5));
        checks++;
        if (rabs(real'(xo) - ex) > 12.0 || yo > 6 || yo < -6) begin
          errors++;
          $display("FAIL rand_vec x=%0d y=%0d: X=%0d Y=%0d, required %0.1f +/-12 and |Y|<=6",
                   x, y, xo, yo, ex);
        end
        checks++;
        if (ang_err(zo, ea) > 8) begin
          errors++;
          $display("FAIL rand_vec_z x=%0d y=%0d z=%0d: Z=%0d, required %0d +/-8 mod 2^16",
                   x, y, z, zo, ea & 16'hFFFF);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    int xo, yo, zo;
    start_op(1'b1, 10000, 10000, 0, 1'b0);
    bus_write(6'h00, 32'd5000);
    repeat (3) @(posedge clk);
    bus_write(6'h0C, 32'h1);
    bus_read(6'h1C, r);
    checks++;
    if (r[2:0] !== 3'b101) begin
      errors++;
      $display("FAIL overrun_status: got %b, required 101", r[2:0]);
    end
    wait_done("overrun");
    read_results(xo, yo, zo);
    checks++;
    if (rabs(real'(xo - 23289)) > 4.0 || ang_err(zo, 32'h2000) > 2) begin
      errors++;
      $display("FAIL overrun_first_result: X=%0d Z=%0d, required 23289 8192", xo, zo);
    end
    bus_write(6'h1C, 32'h4);
    bus_read(6'h1C, r);
    checks++;
    if (r[2:0] !== 3'b010) begin
      errors++;
      $display("FAIL overrun_w1c: got %b, required 010", r[2:0]);
    end
    bus_write(6'h0C, 32'h1);
    wait_done("stored_inputs");
    read_results(xo, yo, zo);
    checks++;
    if (rabs(real'(xo) - A * 5000.0) > 6.0 || rabs(real'(yo) - A * 10000.0) > 6.0) begin
      errors++;
      $display("FAIL stored_inputs: X=%0d Y=%0d, required 8234 16468 +/-6", xo, yo);
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    int px, py, pz, xo, yo, zo;
    read_results(px, py, pz);
    start_op(1'b0, 9949, 0, 32'h2000, 1'b0);
    repeat (4) @(posedge clk);
    bus_write(6'h0C, 32'h8);
    checks++;
    if (uo_out[2:1] !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: DONE,BUSY=%b, required 00", uo_out[2:1]);
    end
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (uo_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: DONE=%b, required 0", uo_out[2]);
    end
    read_results(xo, yo, zo);
    checks++;
    if (xo != px || yo != py || zo != pz) begin
      errors++;
      $display("FAIL abort_outputs: %0d %0d %0d, required %0d %0d %0d", xo, yo, zo, px, py, pz);
    end
    bus_write(6'h0C, 32'h9);
    bus_read(6'h1C, r);
    checks++;
    if (r[2:0] !== 3'b000) begin
      errors++;
      $display("FAIL abort_start_same_write: status=%b, required 000", r[2:0]);
    end
  endtask

  task automatic test_irq();
    start_op(1'b0, 9949, 0, 32'h2000, 1'b1);
    checks++;
    if (user_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL irq_while_busy: got %b, required 0", user_interrupt);
    end
    wait_done("irq");
    checks++;
    if (user_interrupt !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: got %b, required 1", user_interrupt);
    end
    bus_write(6'h1C, 32'h2);
    checks++;
    if (user_interrupt !== 1'b0 || uo_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL irq_w1c: irq=%b done=%b, required 0 0", user_interrupt, uo_out[2]);
    end
    bus_write(6'h0C, 32'h1);
    wait_done("irq_masked");
    checks++;
    if (user_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL irq_masked: got %b, required 0", user_interrupt);
    end
  endtask

  task automatic test_done_set_wins();
    start_op(1'b0, 9949, 0, 32'h2000, 1'b0);
    repeat (16) @(posedge clk);
    bus_write(6'h1C, 32'h2);
    checks++;
    if (uo_out[2] !== 1'b1) begin
      errors++;
      $display("FAIL done_set_wins: DONE=%b, required 1", uo_out[2]);
    end
    bus_write(6'h1C, 32'h2);
    checks++;
    if (uo_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL done_w1c_after: DONE=%b, required 0", uo_out[2]);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    bus_write(6'h00, 32'h0000_1234);
    bus_write(6'h01, 32'h0000_00AB, 2'b00);
    bus_read(6'h00, r);
    checks++;
    if (r !== 32'hFFFF_AB34) begin
      errors++;
      $display("FAIL byte_write: got %h, required ffffab34", r);
    end
    bus_write(6'h04, 32'hABCD_8001, 2'b01);
    bus_read(6'h04, r);
    checks++;
    if (r !== 32'hFFFF_8001) begin
      errors++;
      $display("FAIL half_write: got %h, required ffff8001", r);
    end
    bus_write(6'h08, 32'h0000_0055);
    bus_write(6'h0A, 32'h0000_00FF, 2'b00);
    bus_read(6'h08, r);
    checks++;
    if (r !== 32'h0000_0055) begin
      errors++;
      $display("FAIL upper_lane_write: got %h, required 00000055", r);
    end
    bus_write(6'h20, 32'hFFFF_FFFF);
    bus_read(6'h20, r);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: got %h, required 00000000", r);
    end
    bus_read(6'h00, r);
    checks++;
    if (r !== 32'hFFFF_AB34) begin
      errors++;
      $display("FAIL unmapped_write_alias: X_IN=%h, required ffffab34", r);
    end
    bus_write(6'h0C, 32'h0000_000E);
    bus_read(6'h0C, r);
    checks++;
    if (r !== 32'h0000_0006) begin
      errors++;
      $display("FAIL control_readback: got %h, required 00000006", r);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    start_op(1'b0, 9949, 0, 32'h2000, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00 || user_interrupt !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs: uo_out=%h irq=%b, required 00 0", uo_out, user_interrupt);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(6'(a * 4), r);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL midop_reset_reg_%0h: got %h, required 00000000", a * 4, r);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (uo_out !== 8'h00) begin
      errors++;
      $display("FAIL midop_reset_no_done: uo_out=%h, required 00", uo_out);
    end
  endtask

  initial begin
    ui_in = 8'h00;
    bus.address = '0;
    bus.data_in = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_rotate_directed();
    test_vector_directed();
    test_random();
    test_overrun();
    test_abort();
    test_irq();
    test_done_set_wins();
    test_byte_lanes();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
